// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: states, opcodes,
// funct codes, ALU ops, trap causes and the latched instruction class.
package mips_ctrl_pkg;

    localparam logic [2:0] S_BOOT   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_IMEM    = 2'b10;
    localparam logic [1:0] TRAP_DMEM    = 2'b11;

    typedef enum logic [2:0] {
        CLS_R, CLS_J, CLS_ADDI, CLS_LW, CLS_SW, CLS_BEQ, CLS_BAD
    } ins_class_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational instruction classifier: opcode/funct -> class, ALU op, illegal flag.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    output ins_class_t  cls,
    output logic [2:0]  alu_op,
    output logic        illegal
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        cls    = CLS_BAD;
        alu_op = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_AND:  begin cls = CLS_R; alu_op = ALU_AND; end
                    FN_OR:   begin cls = CLS_R; alu_op = ALU_OR;  end
                    FN_ADD:  begin cls = CLS_R; alu_op = ALU_ADD; end
                    FN_SUB:  begin cls = CLS_R; alu_op = ALU_SUB; end
                    FN_SLT:  begin cls = CLS_R; alu_op = ALU_SLT; end
                    default: cls = CLS_BAD;
                endcase
            end
            OP_J:    cls = CLS_J;
            OP_ADDI: cls = CLS_ADDI;
            OP_LW:   cls = CLS_LW;
            OP_SW:   cls = CLS_SW;
            OP_BEQ:  begin cls = CLS_BEQ; alu_op = ALU_SUB; end
            default: cls = CLS_BAD;
        endcase
    end

    assign illegal = (cls == CLS_BAD);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control FSM (BOOT/FETCH/DECODE/EXEC/MEM/WB/TRAP) for the MIPS datapath.
// Define CTRL_INSTRET_EN to build the retired-instruction counter.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      ins,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic             int_o,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem2reg,
    output logic             branch,
    output logic             jump,
    output logic [2:0]       alu_op,
    output logic             halted,
    output logic [1:0]       trap_cause,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instret
);

    logic [2:0] state, state_d;
    ins_class_t cls_q, dec_cls;
    logic [2:0] alu_op_q, dec_alu_op;
    logic       dec_illegal;
    logic [1:0] cause_q, cause_d;
    logic [7:0] wait_cnt, wait_d;
    logic       ready_sel, waiting, timeout;

    // Only opcode and funct matter for sequencing; the branch flag is consumed by the PC mux.
    logic unused_ins;
    assign unused_ins = ^{ins[25:6], zero};

    mips_ctrl_decode u_decode (
        .op      (ins[31:26]),
        .funct   (ins[5:0]),
        .cls     (dec_cls),
        .alu_op  (dec_alu_op),
        .illegal (dec_illegal)
    );

    assign ready_sel = (state == S_FETCH) ? imem_ready : dmem_ready;
    assign waiting   = ((state == S_FETCH) || (state == S_MEM)) && !ready_sel;
    // This is the WAIT_TIMEOUT-th consecutive low cycle; a ready on this cycle still wins.
    assign timeout   = waiting && (wait_cnt == 8'(WAIT_TIMEOUT - 1));

    always_comb begin
        state_d = state;
        cause_d = cause_q;
        case (state)
            S_BOOT:   state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ready)   state_d = S_DECODE;
                else if (timeout) begin state_d = S_TRAP; cause_d = TRAP_IMEM; end
            end
            S_DECODE: begin
                if (dec_illegal) begin state_d = S_TRAP; cause_d = TRAP_ILLEGAL; end
                else             state_d = S_EXEC;
            end
            S_EXEC: begin
                case (cls_q)
                    CLS_J, CLS_BEQ: state_d = S_FETCH;
                    CLS_LW, CLS_SW: state_d = S_MEM;
                    default:        state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (dmem_ready)   state_d = (cls_q == CLS_LW) ? S_WB : S_FETCH;
                else if (timeout) begin state_d = S_TRAP; cause_d = TRAP_DMEM; end
            end
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_TRAP;
        endcase
    end

    assign wait_d = (waiting && (state_d == state)) ? wait_cnt + 8'd1 : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_BOOT;
            cls_q    <= CLS_BAD;
            alu_op_q <= ALU_ADD;
            cause_q  <= TRAP_NONE;
            wait_cnt <= 8'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            state    <= state_d;
            cause_q  <= cause_d;
            wait_cnt <= wait_d;
            if (state == S_DECODE) begin
                cls_q    <= dec_cls;
                alu_op_q <= dec_alu_op;
            end
        end
    end

    // Moore decode of (state, latched class); BOOT strobes are gated by rst_n so
    // nothing is asserted while reset is held.
    always_comb begin
        ir_we = 1'b0; pc_we = 1'b0; int_o = 1'b0;
        reg_dst = 1'b0; reg_write = 1'b0; alu_src = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; mem2reg = 1'b0;
        branch = 1'b0; jump = 1'b0;
        alu_op = ALU_ADD;
        case (state)
            S_BOOT: begin
                int_o = rst_n;
                pc_we = rst_n;
            end
            S_FETCH: ir_we = imem_ready;
            S_EXEC: begin
                alu_op  = alu_op_q;
                alu_src = (cls_q == CLS_ADDI) || (cls_q == CLS_LW) || (cls_q == CLS_SW);
                branch  = (cls_q == CLS_BEQ);
                jump    = (cls_q == CLS_J);
                pc_we   = (cls_q == CLS_BEQ) || (cls_q == CLS_J);
            end
            S_MEM: begin
                alu_src   = 1'b1;
                mem_read  = (cls_q == CLS_LW);
                mem_write = (cls_q == CLS_SW);
                pc_we     = (cls_q == CLS_SW) && dmem_ready;
            end
            S_WB: begin
                reg_write = 1'b1;
                reg_dst   = (cls_q == CLS_R);
                mem2reg   = (cls_q == CLS_LW);
                pc_we     = 1'b1;
            end
            default: ;
        endcase
    end

    assign halted     = (state == S_TRAP);
    assign trap_cause = cause_q;
    assign state_o    = state;

`ifdef CTRL_INSTRET_EN
    logic [CNT_W-1:0] instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        instret_q <= '0;
        else if (pc_we && state != S_BOOT) instret_q <= instret_q + CNT_W'(1);
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multi-cycle control sequencer for the existing yIF/yID/yEX/yDM/yWB/yPC datapath. It replaces ad-hoc per-instruction control setting with a registered FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives every datapath control line plus the PC and IR write enables. It stalls on memory ready signals and traps on illegal opcodes or memory timeouts.

Parameters:
WAIT_TIMEOUT, 15, maximum consecutive cycles any ready input may stay low before a timeout trap (1..255)
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
ins  input  32  current instruction word from the IR/IF stage
zero  input  1  ALU zero flag from the EX stage
imem_ready  input  1  instruction fetch complete
dmem_ready  input  1  data memory access complete
ir_we  output  1  latch fetched instruction
pc_we  output  1  update PC from the yPC mux
int_o  output  1  PC mux selects the entry point (boot)
reg_dst, reg_write, alu_src, mem_read, mem_write, mem2reg, branch, jump  output  1 each  datapath controls
alu_op  output  3  000 and, 001 or, 010 add, 110 sub, 111 slt
halted  output  1  FSM is in TRAP
trap_cause  output  2  00 none, 01 illegal opcode/funct, 10 imem timeout, 11 dmem timeout
state_o  output  3  current state encoding, for debug
instret  output  CNT_W  retired-instruction count (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state=BOOT; all controls 0; alu_op=010; halted=0; trap_cause=00; wait counter=0; instret=0.
- States are BOOT, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- BOOT: int_o=1, pc_we=1 for exactly one cycle, then FETCH.
- FETCH: ir_we=imem_ready. On ready, go to DECODE; otherwise stay.
- DECODE: register the instruction class from ins[31:26] and ins[5:0]. Supported: R-type (funct 24/25/20/22/2a), j (op 2), addi (8), lw (23), sw (2b), beq (4). Anything else goes to TRAP with cause 01.
- EXEC:
  - alu_op and alu_src are valid: R-type uses the funct mapping; addi/lw/sw use add with alu_src=1; beq uses sub with alu_src=0.
  - beq: branch=1, pc_we=1, then FETCH.
  - j: jump=1, pc_we=1, then FETCH.
  - lw/sw: go to MEM.
  - R-type/addi: go to WB.
- MEM: alu_op=add and alu_src=1 held. mem_read (lw) or mem_write (sw) is held until dmem_ready.
  - On ready, lw goes to WB.
  - On ready, sw asserts pc_we=1 and goes to FETCH.
- WB: reg_write=1. reg_dst=1 for R-type only. mem2reg=1 for lw only. pc_we=1, then FETCH.
- Control outputs are a Moore decode of (state, latched class). They never depend combinationally on ins. They depend on the ready inputs only where stated.
- Latency with ready=1 every cycle: beq/j 3 cycles, R/addi/sw 4 cycles, lw 5 cycles.
- The wait counter increments each cycle in FETCH/MEM while ready=0, and clears on ready or state change.
  - Reaching WAIT_TIMEOUT enters TRAP with cause 10 (FETCH) or 11 (MEM).
  - Ready asserted on the same cycle the counter hits the limit wins: no trap.
- TRAP: all controls 0, halted=1, trap_cause held. Only rst_n exits.
- Reset asserted mid-instruction aborts it immediately. No partial register or memory write follows, because controls drop asynchronously.

Optional Feature:
CTRL_INSTRET_EN.
- Defined: instret increments by 1 on every retiring transition (the pc_we cycle of any state other than BOOT). It wraps modulo 2^CNT_W and is cleared by reset.
- Undefined: instret is tied to 0 and no counter flops are generated.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state encodings
  - opcode constants (OP_RTYPE=0, OP_J=2, OP_BEQ=4, OP_ADDI=8, OP_LW=23h, OP_SW=2Bh)
  - funct constants
  - ALU op codes
  - trap cause codes
  - instruction class enum
- One sub-module: mips_ctrl_decode, combinational ins -> {class, alu_op, illegal}, instantiated inside the FSM.

Test Plan:
- Reset release, then `add $3,$1,$2` (00221820) with ready=1 -> BOOT one cycle with int_o=pc_we=1; then F/D/E/W in 4 cycles; reg_write=reg_dst=1 in WB; alu_op=010.
- lw (8C220004) with dmem_ready low 3 cycles -> mem_read held 4 cycles, WB with mem2reg=1; total 8 cycles from FETCH.
- beq (10220003) with zero=1 -> EXEC asserts branch=1, pc_we=1, alu_op=110; back in FETCH on cycle 4; no reg_write pulse.
- Opcode 3Fh -> TRAP after DECODE; halted=1, trap_cause=01; all controls 0 until rst_n low.
- imem_ready held 0 -> trap cause 10 after exactly WAIT_TIMEOUT=15 wait cycles. Repeat with ready rising on cycle 15 -> no trap.
- CTRL_INSTRET_EN defined, run 10 instructions mixing all classes -> instret=10. Pulse rst_n mid-MEM -> instret=0, state=BOOT, mem_write drops immediately.
